// File: rtl/eth_tx_arbiter_if.sv
// Bundle of the two TX-engine request/data ports and the GMII output side of
// the arbiter. master = frame generators / PHY side, slave = the arbiter.
interface eth_tx_arbiter_if;
  // Port A (ARP transmitter)
  logic       a_req;
  logic       a_start;
  logic       a_tx_en;
  logic [7:0] a_txd;
  logic       a_done;
  // Port B (ICMP transmitter)
  logic       b_req;
  logic       b_start;
  logic       b_tx_en;
  logic [7:0] b_txd;
  logic       b_done;
  // Shared GMII transmit port and status
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  modport master (
    output a_req, a_tx_en, a_txd, a_done,
    output b_req, b_tx_en, b_txd, b_done,
    input  a_start, b_start, gmii_tx_en, gmii_txd, grant, busy, timeout_err
  );

  modport slave (
    input  a_req, a_tx_en, a_txd, a_done,
    input  b_req, b_tx_en, b_txd, b_done,
    output a_start, b_start, gmii_tx_en, gmii_txd, grant, busy, timeout_err
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one GMII TX port between an ARP
// and an ICMP frame generator. All outputs are registered; data is forwarded
// with one cycle of latency. Enforces an inter-frame gap and a frame timeout.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter logic [15:0] MAX_FRAME_CYC = 16'd3000
) (
  input logic              clk,
  input logic              rst_n,
  eth_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StIfg} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_b_q, last_b_d;     // 1: B owned the port most recently
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] ifg_cnt_q, ifg_cnt_d;
  logic        a_start_q, a_start_d;
  logic        b_start_q, b_start_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;

  // Only the owner's inputs are ever looked at; the other port is ignored.
  logic       sel_tx_en;
  logic [7:0] sel_txd;
  logic       sel_done;

  assign sel_tx_en = grant_q[1] ? bus.b_tx_en : bus.a_tx_en;
  assign sel_txd   = grant_q[1] ? bus.b_txd   : bus.a_txd;
  assign sel_done  = grant_q[1] ? bus.b_done  : bus.a_done;

  // Next-state, grant decision and registered-output values.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_b_d    = last_b_q;
    frame_cnt_d = frame_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    a_start_d   = 1'b0;
    b_start_d   = 1'b0;
    tx_en_d     = 1'b0;
    txd_d       = 8'h00;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A wins when alone, or on contention when B went last.
        if (bus.a_req && (!bus.b_req || last_b_q)) begin
          grant_d   = 2'b01;
          last_b_d  = 1'b0;
          a_start_d = 1'b1;
          state_d   = StStart;
        end else if (bus.b_req) begin
          grant_d   = 2'b10;
          last_b_d  = 1'b1;
          b_start_d = 1'b1;
          state_d   = StStart;
        end
      end

      StStart: begin
        frame_cnt_d = 16'd0;
        state_d     = StSend;
      end

      StSend: begin
        if (sel_done) begin
          // The byte presented alongside done is still part of the frame.
          tx_en_d   = sel_tx_en;
          txd_d     = sel_txd;
          ifg_cnt_d = 16'd0;
          state_d   = StIfg;
        end else if (frame_cnt_q >= MAX_FRAME_CYC - 16'd1) begin
          // Truncate: dropping tx_en mid-frame leaves the PHY with a bad CRC.
          timeout_d = 1'b1;
          ifg_cnt_d = 16'd0;
          state_d   = StIfg;
        end else begin
          tx_en_d = sel_tx_en;
          txd_d   = sel_txd;
          if (frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end

      StIfg: begin
        if (ifg_cnt_q == 16'(IFG_CYCLES - 1)) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset drops the GMII port immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      last_b_q    <= 1'b1;
      frame_cnt_q <= 16'd0;
      ifg_cnt_q   <= 16'd0;
      a_start_q   <= 1'b0;
      b_start_q   <= 1'b0;
      tx_en_q     <= 1'b0;
      txd_q       <= 8'h00;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_b_q    <= last_b_d;
      frame_cnt_q <= frame_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      a_start_q   <= a_start_d;
      b_start_q   <= b_start_d;
      tx_en_q     <= tx_en_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.a_start     = a_start_q;
  assign bus.b_start     = b_start_q;
  assign bus.gmii_tx_en  = tx_en_q;
  assign bus.gmii_txd    = txd_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter (IFG_CYCLES=12, MAX_FRAME_CYC=100).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_eth_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  eth_tx_arbiter_if bus_if ();

  eth_tx_arbiter #(
    .IFG_CYCLES   (12),
    .MAX_FRAME_CYC(16'd100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.a_req = 1'b0; bus_if.a_tx_en = 1'b0; bus_if.a_txd = 8'h00; bus_if.a_done = 1'b0;
    bus_if.b_req = 1'b0; bus_if.b_tx_en = 1'b0; bus_if.b_txd = 8'h00; bus_if.b_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called while the arbiter is in START. Plays n bytes from one port (optionally
  // with noise on the other port) and counts bytes not forwarded 1 cycle later.
  task automatic play_frame(input bit port_b, input int n, input bit noise,
                            input bit with_done, output int bad, output int starts);
    logic [7:0] bv;
    bad = 0;
    starts = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      bv = 8'(8'h55 + (i * 128) / 63);
      if (port_b) begin
        bus_if.b_tx_en = 1'b1; bus_if.b_txd = bv; bus_if.b_done = with_done && (i == n - 1);
        bus_if.a_tx_en = noise; bus_if.a_txd = noise ? 8'hFF : 8'h00;
        bus_if.a_done  = noise && (i == n / 2);
      end else begin
        bus_if.a_tx_en = 1'b1; bus_if.a_txd = bv; bus_if.a_done = with_done && (i == n - 1);
        bus_if.b_tx_en = noise; bus_if.b_txd = noise ? 8'hFF : 8'h00;
        bus_if.b_done  = noise && (i == n / 2);
      end
      tick();
      if (bus_if.gmii_tx_en !== 1'b1 || bus_if.gmii_txd !== bv) bad++;
      if (bus_if.a_start || bus_if.b_start) starts++;
    end
    bus_if.a_tx_en = 1'b0; bus_if.a_txd = 8'h00; bus_if.a_done = 1'b0;
    bus_if.b_tx_en = 1'b0; bus_if.b_txd = 8'h00; bus_if.b_done = 1'b0;
  endtask

  // Bounded wait for the next start strobe; n = -1 if none within 64 cycles.
  task automatic wait_start(output int n, output bit got_a, output bit got_b);
    got_a = 1'b0;
    got_b = 1'b0;
    n = -1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (bus_if.a_start || bus_if.b_start) begin
        got_a = bus_if.a_start;
        got_b = bus_if.b_start;
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    outs = {bus_if.a_start, bus_if.b_start, bus_if.gmii_tx_en, bus_if.gmii_txd,
            bus_if.grant, bus_if.busy, bus_if.timeout_err};
    tests_run++;
    if (outs !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected 0000", outs);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b grant=%b, expected 0/00",
               bus_if.busy, bus_if.grant);
    end
  endtask

  task automatic test_single_a();
    int bad, st, errs;
    bus_if.a_req = 1'b1;
    tick();
    tests_run++;
    if ({bus_if.a_start, bus_if.b_start, bus_if.grant, bus_if.busy} !== 5'b10011) begin
      tests_failed++;
      $display("FAIL single_start: a_start=%b b_start=%b grant=%b busy=%b, expected 1 0 01 1",
               bus_if.a_start, bus_if.b_start, bus_if.grant, bus_if.busy);
    end
    bus_if.a_req = 1'b0;
    play_frame(1'b0, 64, 1'b0, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0 || st !== 0) begin
      tests_failed++;
      $display("FAIL single_data: bad_bytes=%0d extra_starts=%0d, expected 0 0", bad, st);
    end
    errs = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (bus_if.gmii_tx_en !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.grant !== 2'b01 ||
          bus_if.a_start !== 1'b0 || bus_if.b_start !== 1'b0) errs++;
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++;
      $display("FAIL single_ifg: %0d bad gap cycles, expected 0", errs);
    end
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_release: busy=%b grant=%b, expected 0 00", bus_if.busy, bus_if.grant);
    end
  endtask

  task automatic test_contention();
    int bad, st, errs;
    do_reset();
    bus_if.a_req = 1'b1;
    bus_if.b_req = 1'b1;
    tick();
    tests_run++;
    if (bus_if.grant !== 2'b01 || bus_if.a_start !== 1'b1 || bus_if.b_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_first: grant=%b a_start=%b b_start=%b, expected 01 1 0",
               bus_if.grant, bus_if.a_start, bus_if.b_start);
    end
    bus_if.a_req = 1'b0;
    play_frame(1'b0, 8, 1'b0, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL contention_a_data: bad_bytes=%0d, expected 0", bad);
    end
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus_if.gmii_tx_en !== 1'b0 || bus_if.b_start !== 1'b0) errs++;
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++;
      $display("FAIL contention_gap: %0d early cycles, expected 0", errs);
    end
    tick();
    tests_run++;
    if (bus_if.b_start !== 1'b1 || bus_if.grant !== 2'b10) begin
      tests_failed++;
      $display("FAIL contention_second: b_start=%b grant=%b, expected 1 10",
               bus_if.b_start, bus_if.grant);
    end
    bus_if.b_req = 1'b0;
    play_frame(1'b1, 8, 1'b0, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL contention_b_data: bad_bytes=%0d, expected 0", bad);
    end
  endtask

  task automatic test_round_robin();
    int n, bad, st;
    bit ga, gb;
    bit exp_b;
    bus_if.a_req = 1'b1;
    bus_if.b_req = 1'b1;
    for (int f = 0; f < 4; f++) begin
      exp_b = (f % 2) == 1;
      wait_start(n, ga, gb);
      tests_run++;
      if (n !== 13 || ga !== !exp_b || gb !== exp_b || bus_if.grant !== {exp_b, !exp_b}) begin
        tests_failed++;
        $display("FAIL rr_frame%0d: wait=%0d a_start=%b b_start=%b grant=%b, expected 13 %b %b %b%b",
                 f, n, ga, gb, bus_if.grant, !exp_b, exp_b, exp_b, !exp_b);
      end
      if (n < 0) return;
      play_frame(exp_b, 6, 1'b0, 1'b1, bad, st);
      tests_run++;
      if (bad !== 0 || st !== 0) begin
        tests_failed++;
        $display("FAIL rr_data%0d: bad_bytes=%0d extra_starts=%0d, expected 0 0", f, bad, st);
      end
    end
    bus_if.a_req = 1'b0;
    bus_if.b_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n, bad, st, errs;
    bit ga, gb;
    do_reset();
    bus_if.b_req = 1'b1;
    wait_start(n, ga, gb);
    tests_run++;
    if (n !== 1 || gb !== 1'b1 || ga !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_grant_b: wait=%0d a=%b b=%b, expected 1 0 1", n, ga, gb);
    end
    bus_if.b_req = 1'b0;
    bus_if.a_req = 1'b1;
    tick();
    bus_if.b_tx_en = 1'b1;
    bus_if.b_txd   = 8'h3C;
    errs = 0;
    for (int k = 0; k < 99; k++) begin
      tick();
      if (bus_if.gmii_tx_en !== 1'b1 || bus_if.timeout_err !== 1'b0) errs++;
    end
    tests_run++;
    if (errs !== 0) begin
      tests_failed++;
      $display("FAIL timeout_early: %0d bad cycles before limit, expected 0", errs);
    end
    tick();
    tests_run++;
    if (bus_if.timeout_err !== 1'b1 || bus_if.gmii_tx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fire: timeout_err=%b gmii_tx_en=%b, expected 1 0",
               bus_if.timeout_err, bus_if.gmii_tx_en);
    end
    bus_if.b_tx_en = 1'b0;
    bus_if.b_txd   = 8'h00;
    tick();
    tests_run++;
    if (bus_if.timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: timeout_err=%b, expected 0", bus_if.timeout_err);
    end
    wait_start(n, ga, gb);
    tests_run++;
    if (n !== 12 || ga !== 1'b1 || bus_if.grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL timeout_next_a: wait=%0d a_start=%b grant=%b, expected 12 1 01",
               n, ga, bus_if.grant);
    end
    bus_if.a_req = 1'b0;
    if (n < 0) return;
    play_frame(1'b0, 8, 1'b0, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL timeout_a_data: bad_bytes=%0d, expected 0", bad);
    end
  endtask

  task automatic test_isolation();
    int n, bad, st;
    bit ga, gb;
    bus_if.a_req = 1'b1;
    wait_start(n, ga, gb);
    bus_if.a_req = 1'b0;
    tests_run++;
    if (ga !== 1'b1) begin
      tests_failed++;
      $display("FAIL iso_start: a_start=%b, expected 1", ga);
    end
    if (n < 0) return;
    play_frame(1'b0, 16, 1'b1, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0 || st !== 0) begin
      tests_failed++;
      $display("FAIL iso_data: bad_bytes=%0d extra_starts=%0d, expected 0 0", bad, st);
    end
    tick();
    tests_run++;
    if (bus_if.gmii_tx_en !== 1'b0 || bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL iso_end: gmii_tx_en=%b busy=%b, expected 0 1",
               bus_if.gmii_tx_en, bus_if.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, bad, st;
    bit ga, gb;
    bus_if.a_req = 1'b1;
    wait_start(n, ga, gb);
    bus_if.a_req = 1'b0;
    play_frame(1'b0, 20, 1'b0, 1'b0, bad, st);
    tests_run++;
    if (bad !== 0 || ga !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_prefix: bad_bytes=%0d a_start=%b, expected 0 1", bad, ga);
    end
    bus_if.a_tx_en = 1'b1;
    bus_if.a_txd   = 8'hA7;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.gmii_tx_en !== 1'b0 || bus_if.grant !== 2'b00 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: gmii_tx_en=%b grant=%b busy=%b, expected 0 00 0",
               bus_if.gmii_tx_en, bus_if.grant, bus_if.busy);
    end
    bus_if.a_tx_en = 1'b0;
    bus_if.a_txd   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    st = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus_if.a_start || bus_if.b_start || bus_if.busy) st++;
    end
    tests_run++;
    if (st !== 0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: %0d active cycles without req, expected 0", st);
    end
    bus_if.a_req = 1'b1;
    tick();
    tests_run++;
    if (bus_if.a_start !== 1'b1 || bus_if.grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL midrst_restart: a_start=%b grant=%b, expected 1 01",
               bus_if.a_start, bus_if.grant);
    end
    bus_if.a_req = 1'b0;
    play_frame(1'b0, 4, 1'b0, 1'b1, bad, st);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midrst_frame: bad_bytes=%0d, expected 0", bad);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_a();
    test_contention();
    test_round_robin();
    test_timeout();
    test_isolation();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
